// File: rtl/fifo_drain_ctrl_if.sv
// Handshake bundle between fifo_flops, the drain stage and the next pipeline stage.
// master = drain controller side, slave = FIFO/downstream environment side.
interface fifo_drain_ctrl_if #(
    parameter int BITS = 16
);
    logic [BITS-1:0] fifo_dout;
    logic            fifo_pndng;
    logic            fifo_pop;
    logic [BITS-1:0] out_data;
    logic            out_valid;
    logic            out_ready;

    modport master (
        input  fifo_dout,
        input  fifo_pndng,
        input  out_ready,
        output fifo_pop,
        output out_data,
        output out_valid
    );

    modport slave (
        output fifo_dout,
        output fifo_pndng,
        output out_ready,
        input  fifo_pop,
        input  out_data,
        input  out_valid
    );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// Drains fifo_flops into a 2-entry head/skid buffer presented as valid/ready.
// Optional statistics counters are enabled with FIFO_DRAIN_STATS_EN.
module fifo_drain_ctrl #(
    parameter int BITS  = 16,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    output logic               busy,
    fifo_drain_ctrl_if.master  bus
`ifdef FIFO_DRAIN_STATS_EN
    ,
    output logic [CNT_W-1:0]   cnt_words,
    output logic [CNT_W-1:0]   cnt_stall
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t          state;
    logic [BITS-1:0] head;
    logic [BITS-1:0] skid;
    logic            valid_q;
    logic            push;
    logic            take;

    // Pop depends only on registered occupancy, never on out_ready.
    assign push         = rst & bus.fifo_pndng & ~flush & (state != TWO);
    assign take         = valid_q & bus.out_ready;
    assign bus.fifo_pop = push;
    assign bus.out_data = head;
    assign bus.out_valid = valid_q;
    assign busy         = (state != EMPTY) | bus.fifo_pndng;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
            head    <= '0;
            skid    <= '0;
        end else if (flush) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head    <= bus.fifo_dout;
                        state   <= ONE;
                        valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (push && take) begin
                        head <= bus.fifo_dout;
                    end else if (push) begin
                        skid  <= bus.fifo_dout;
                        state <= TWO;
                    end else if (take) begin
                        state   <= EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                TWO: begin
                    if (take) begin
                        head  <= skid;
                        state <= ONE;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_DRAIN_STATS_EN
    // Saturating counters; flush restarts the statistics window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_words <= '0;
            cnt_stall <= '0;
        end else if (flush) begin
            cnt_words <= '0;
            cnt_stall <= '0;
        end else begin
            if (take && (cnt_words != {CNT_W{1'b1}})) begin
                cnt_words <= cnt_words + CNT_W'(1);
            end
            if (valid_q && !bus.out_ready && (cnt_stall != {CNT_W{1'b1}})) begin
                cnt_stall <= cnt_stall + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl: a queue models fifo_flops and a scoreboard
// tracks popped words so every transfer is checked for order.
module tb_fifo_drain_ctrl;

    localparam int BITS = 16;

    logic clk;
    logic rst;
    logic flush;
    logic busy;

    fifo_drain_ctrl_if #(.BITS(BITS)) bus ();

`ifdef FIFO_DRAIN_STATS_EN
    logic [31:0] cnt_words;
    logic [31:0] cnt_stall;
    logic [3:0]  cnt_words4;
    logic [3:0]  cnt_stall4;
    logic        busy4;

    fifo_drain_ctrl_if #(.BITS(BITS)) bus4 ();
    assign bus4.fifo_dout  = bus.fifo_dout;
    assign bus4.fifo_pndng = bus.fifo_pndng;
    assign bus4.out_ready  = bus.out_ready;

    fifo_drain_ctrl #(.BITS(BITS), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .busy(busy), .bus(bus),
        .cnt_words(cnt_words), .cnt_stall(cnt_stall)
    );

    fifo_drain_ctrl #(.BITS(BITS), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .busy(busy4), .bus(bus4),
        .cnt_words(cnt_words4), .cnt_stall(cnt_stall4)
    );
`else
    fifo_drain_ctrl #(.BITS(BITS), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .busy(busy), .bus(bus)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int              num_checks = 0;
    int              num_errors = 0;
    logic [BITS-1:0] fq[$];
    logic [BITS-1:0] sb[$];
    int              occ = 0;
    int              pops = 0;
    int              takes = 0;
    logic            last_pop;
    logic            last_valid;
    logic            last_take;
    logic [BITS-1:0] last_data;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic loadWords(input int first, input int n);
        for (int i = 0; i < n; i++) fq.push_back(BITS'(first + i));
    endtask

    // One clock: drive at negedge, sample 1ns later, update FIFO model at posedge.
    task automatic applyStimulus(input logic rdy, input logic fl);
        logic [BITS-1:0] exp;
        bus.out_ready  = rdy;
        flush          = fl;
        bus.fifo_pndng = (fq.size() != 0);
        bus.fifo_dout  = (fq.size() != 0) ? fq[0] : '0;
        #1;
        last_pop   = bus.fifo_pop;
        last_valid = bus.out_valid;
        last_data  = bus.out_data;
        last_take  = last_valid & rdy;
        if (occ == 2) checkOutput("pop_in_two", 32'(last_pop), 32'd0);
        if (last_take) begin
            checkOutput("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                checkOutput("order", 32'(last_data), 32'(exp));
            end
            takes++;
        end
        if (last_pop) pops++;
        @(posedge clk);
        if (last_pop && fq.size() != 0) sb.push_back(fq.pop_front());
        if (fl) begin
            sb.delete();
            occ = 0;
        end else begin
            occ = occ + int'(last_pop) - int'(last_take);
        end
        @(negedge clk);
    endtask

    task automatic resetDut();
        rst            = 1'b0;
        flush          = 1'b0;
        bus.out_ready  = 1'b0;
        bus.fifo_pndng = 1'b0;
        bus.fifo_dout  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        fq.delete();
        occ = 0;
    endtask

    initial begin
        logic [17:0] pop_hist;
        int          p0;
        int          t0;

        // Reset state, with pndng high to prove pop is held off.
        rst            = 1'b0;
        flush          = 1'b0;
        bus.out_ready  = 1'b1;
        bus.fifo_pndng = 1'b1;
        bus.fifo_dout  = 16'hBEEF;
        @(negedge clk);
        #1;
        checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_data", 32'(bus.out_data), 32'd0);
        checkOutput("rst_pop", 32'(bus.fifo_pop), 32'd0);
        @(negedge clk);
        rst            = 1'b1;
        bus.fifo_pndng = 1'b0;
        #1;
        checkOutput("idle_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // Test 1: sustained drain of 0..15.
        $display("[TB] test 1: streaming drain");
        loadWords(0, 16);
        pop_hist = '0;
        t0 = takes;
        for (int c = 0; c < 18; c++) begin
            applyStimulus(1'b1, 1'b0);
            pop_hist[c] = last_pop;
            if (c == 0) begin
                checkOutput("valid_before_pop", 32'(last_valid), 32'd0);
                checkOutput("busy_pending", 32'(busy), 32'd1);
            end
            if (c == 1) begin
                checkOutput("first_valid", 32'(last_valid), 32'd1);
                checkOutput("first_data", 32'(last_data), 32'd0);
            end
        end
        checkOutput("pop_pattern", 32'(pop_hist), 32'h0FFFF);
        checkOutput("t1_takes", 32'(takes - t0), 32'd16);

        // Test 2: backpressure fills both entries then stops popping.
        $display("[TB] test 2: backpressure");
        loadWords(0, 16);
        p0 = pops;
        t0 = takes;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b0, 1'b0);
            if (c >= 1) checkOutput("hold_data", 32'(last_data), 32'd0);
            if (c >= 1) checkOutput("hold_valid", 32'(last_valid), 32'd1);
        end
        checkOutput("two_pops", 32'(pops - p0), 32'd2);
        for (int c = 0; c < 22; c++) applyStimulus(1'b1, 1'b0);
        checkOutput("t2_takes", 32'(takes - t0), 32'd16);
        checkOutput("t2_sb_empty", 32'(sb.size()), 32'd0);

        // Test 3: alternating ready over 20 words.
        $display("[TB] test 3: toggling ready");
        loadWords(100, 20);
        t0 = takes;
        for (int c = 0; c < 50; c++) applyStimulus(((c % 2) == 0) ? 1'b1 : 1'b0, 1'b0);
        checkOutput("t3_takes", 32'(takes - t0), 32'd20);
        checkOutput("t3_fifo_empty", 32'(fq.size()), 32'd0);

        // Test 4: flush with words 4 and 5 buffered.
        $display("[TB] test 4: flush in TWO");
        loadWords(4, 6);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("flush_pop", 32'(last_pop), 32'd0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("flush_valid", 32'(last_valid), 32'd0);
        checkOutput("post_flush_pop", 32'(last_pop), 32'd1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("post_flush_data", 32'(last_data), 32'd6);
        for (int c = 0; c < 8; c++) applyStimulus(1'b1, 1'b0);
        checkOutput("t4_sb_empty", 32'(sb.size()), 32'd0);

        // Test 5: asynchronous reset while two words are buffered.
        $display("[TB] test 5: reset mid-stream");
        loadWords(20, 10);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mid_rst_pop", 32'(bus.fifo_pop), 32'd0);
        checkOutput("mid_rst_data", 32'(bus.out_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        occ = 0;
        applyStimulus(1'b1, 1'b0);
        checkOutput("resume_valid", 32'(last_valid), 32'd0);
        checkOutput("resume_pop", 32'(last_pop), 32'd1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("resume_data", 32'(last_data), 32'd22);
        for (int c = 0; c < 10; c++) applyStimulus(1'b1, 1'b0);
        checkOutput("t5_fifo_empty", 32'(fq.size()), 32'd0);

`ifdef FIFO_DRAIN_STATS_EN
        // Test 6: 20 words with ready low for five valid cycles.
        $display("[TB] test 6: statistics");
        resetDut();
        loadWords(0, 20);
        for (int c = 0; c < 35; c++) applyStimulus((c >= 3 && c <= 7) ? 1'b0 : 1'b1, 1'b0);
        checkOutput("cnt_words", cnt_words, 32'd20);
        checkOutput("cnt_stall", cnt_stall, 32'd5);
        checkOutput("cnt_words_sat", 32'(cnt_words4), 32'd15);
        checkOutput("cnt_stall4", 32'(cnt_stall4), 32'd5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
